ins_encoder: RTL and testbench
==============================

# ins_encoder

Pipelined instruction encoder: the inverse of the decode-stage immediate extender. It accepts instruction fields plus a full 32-bit immediate and an instruction-format code, checks that the immediate is representable in that format, and scatters it into the RV32I bit positions. Each result is emitted as a 32-bit word tagged with a sequential byte address, for loading instruction memory from a test/boot controller or for generating self-check stimulus.

## Interface
Parameters:
- RESET_ADDR, 32'h0000_0000, address assigned to the first instruction after reset.
- NOP_WORD, 32'h0000_0013, word substituted for rejected instructions (addi x0,x0,0).
- ERR_CNT_W, 8, width of the saturating error counter.

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  synchronous active-high reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  request accepted when IN_VALID & IN_READY.
- IN_TYPE  in  3  format code using the define.v constants I, S, B, U, J; any other code is R-type.
- IN_OPCODE  in  7  opcode, goes to [6:0].
- IN_RD, IN_RS1, IN_RS2  in  5 each  register fields.
- IN_FUNCT3  in  3; IN_FUNCT7  in  7.
- IN_IMM  in  32  immediate value in the same form the extender produces.
- ADDR_LOAD  in  1  load address counter with ADDR_VAL.
- ADDR_VAL  in  32  new address; bits [1:0] forced to 0.
- OUT_VALID  out  1; OUT_READY  in  1  output handshake.
- OUT_INS  out  32  encoded word.
- OUT_ADDR  out  32  byte address of OUT_INS.
- OUT_ERR  out  1  immediate not representable; OUT_INS = NOP_WORD.
- ERR_CNT  out  ERR_CNT_W  rejected-request count, saturates at all-ones.

## Operation
- Stage 1 (accept): latch fields and the current address counter value, then advance the counter by 4. ERR and all later cases are derived from the latched fields.
- Range check, on accept:
  - I/S: IN_IMM[31:11] must all be equal.
  - B: IN_IMM[31:12] must all be equal, and IN_IMM[0] must be 0.
  - J: IN_IMM[31:20] must all be equal, and IN_IMM[0] must be 0.
  - U: IN_IMM[11:0] must be 0.
  - R: always legal; IN_IMM is ignored.
- Stage 2 (pack), registered into the output stage:
  - R: funct7[31:25] rs2[24:20] rs1[19:15] funct3[14:12] rd[11:7] opcode[6:0].
  - I: imm[11:0]->[31:20], then rs1, funct3, rd, opcode.
  - S: imm[11:5]->[31:25], rs2, rs1, funct3, imm[4:0]->[11:7], opcode.
  - B: imm[12]->31, imm[10:5]->[30:25], rs2, rs1, funct3, imm[4:1]->[11:8], imm[11]->7, opcode.
  - U: imm[31:12]->[31:12], rd, opcode.
  - J: imm[20]->31, imm[10:1]->[30:21], imm[11]->20, imm[19:12]->[19:12], rd, opcode.
- Fields not used by a format are driven 0.
- Errored entries are still emitted and still consume an address, so program layout is preserved. They carry OUT_ERR=1 and OUT_INS=NOP_WORD.
- ERR_CNT increments at stage-1 accept of an illegal request and saturates.
- ADDR_LOAD sets the counter to {ADDR_VAL[31:2],2'b00}.
  - If a request is accepted in the same cycle, that request takes the loaded address and the counter becomes ADDR_VAL+4.
  - Counter wraps 32'hFFFF_FFFC -> 0 silently.

## Timing
- Reset values: OUT_VALID=0, OUT_INS=0, OUT_ADDR=0, OUT_ERR=0, ERR_CNT=0, address counter=RESET_ADDR. Both stage valids are cleared. IN_READY=1 in the cycle after reset deasserts; IN_READY is 0 while RST is high.
- Latency: OUT_VALID rises 2 cycles after the accept edge with no stall. Throughput is 1 per cycle.
- Handshake:
  - Stage 2 loads when empty or when OUT_READY=1. Stage 1 advances when stage 2 loads.
  - IN_READY = !s1_valid | stage-2 load; IN_READY is combinational from OUT_READY.
- OUT_* hold stable while OUT_VALID=1 and OUT_READY=0.
- Ordering is strict FIFO. At most 2 entries are in flight; no entry is dropped or duplicated.
- RST mid-operation discards in-flight entries. It has priority over ADDR_LOAD and accept in the same cycle.

## Test plan
- I-type: opcode 0010011, rd=1, rs1=0, f3=0, IMM=32'hFFFF_FFFF -> OUT_INS=32'hFFF0_0093, OUT_ADDR=0, OUT_ERR=0, OUT_VALID 2 cycles after accept.
- B-type: opcode 1100011, rs1=1, rs2=2, f3=0, IMM=32'hFFFF_FFFC -> 32'hFE20_8EE3. Then IMM=3 -> OUT_ERR=1, OUT_INS=32'h0000_0013, ERR_CNT=1, address advanced by 4.
- U-type: opcode 0110111, rd=5, IMM=32'h1234_5000 -> 32'h1234_52B7. IMM=32'h1234_5001 -> error.
- Backpressure: OUT_READY=0, issue 3 back-to-back requests.
  - IN_READY drops after 2 accepts; the third is held.
  - Release OUT_READY -> outputs in order with addresses 0, 4, 8.
- ADDR_LOAD=1 with ADDR_VAL=32'h0000_0103 coincident with accept -> that entry has OUT_ADDR=32'h100 and the next has 32'h104. A counter at 32'hFFFF_FFFC wraps to 0.
- Round trip: random legal fields and IMM for each TYPE, fed through ins_encoder then the ImmExtend decoder -> the decoder returns IN_IMM exactly. Also assert RST with both stages full -> OUT_VALID=0 next cycle, ERR_CNT=0, next OUT_ADDR=RESET_ADDR.

Source files
------------

// File: rtl/ins_encoder.sv
// ins_encoder: two-stage RV32I instruction encoder.
// Stage 1 latches the request, its byte address and an immediate range check.
// Stage 2 scatters the immediate into the format's bit positions and
// presents the word with a valid/ready handshake. Rejected requests emit NOP_WORD.
module ins_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [2:0]           IN_TYPE,
  input  logic [6:0]           IN_OPCODE,
  input  logic [4:0]           IN_RD,
  input  logic [4:0]           IN_RS1,
  input  logic [4:0]           IN_RS2,
  input  logic [2:0]           IN_FUNCT3,
  input  logic [6:0]           IN_FUNCT7,
  input  logic [31:0]          IN_IMM,
  input  logic                 ADDR_LOAD,
  input  logic [31:0]          ADDR_VAL,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [31:0]          OUT_INS,
  output logic [31:0]          OUT_ADDR,
  output logic                 OUT_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  // Instruction format codes; any code outside this set is treated as R-type.
  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] addr;
    logic        err;
  } s1_t;

  fmt_e                 in_fmt;
  logic                 in_legal;
  logic                 accept;
  logic                 s2_load;
  logic [31:0]          load_addr;
  logic [31:0]          entry_addr;

  logic [31:0]          addr_q, addr_d;
  logic                 s1_valid_q, s1_valid_d;
  s1_t                  s1_q, s1_d;
  logic [31:0]          packed_ins;

  logic                 out_valid_q, out_valid_d;
  logic [31:0]          out_ins_q, out_ins_d;
  logic [31:0]          out_addr_q, out_addr_d;
  logic                 out_err_q, out_err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Map the incoming format code onto the internal format enum.
  always_comb begin
    in_fmt = FMT_R;
    case (IN_TYPE)
      FMT_I:   in_fmt = FMT_I;
      FMT_S:   in_fmt = FMT_S;
      FMT_B:   in_fmt = FMT_B;
      FMT_U:   in_fmt = FMT_U;
      FMT_J:   in_fmt = FMT_J;
      default: in_fmt = FMT_R;
    endcase
  end

  // Immediate representability: upper bits must be a pure sign extension,
  // branch/jump offsets must be even, and U-type low bits must be clear.
  always_comb begin
    in_legal = 1'b1;
    case (in_fmt)
      FMT_I, FMT_S: in_legal = (&IN_IMM[31:11]) | ~(|IN_IMM[31:11]);
      FMT_B:        in_legal = ((&IN_IMM[31:12]) | ~(|IN_IMM[31:12])) & ~IN_IMM[0];
      FMT_J:        in_legal = ((&IN_IMM[31:20]) | ~(|IN_IMM[31:20])) & ~IN_IMM[0];
      FMT_U:        in_legal = ~(|IN_IMM[11:0]);
      default:      in_legal = 1'b1;
    endcase
  end

  // Handshake: the output stage loads when empty or drained; stage 1 follows it.
  always_comb begin
    s2_load  = ~out_valid_q | OUT_READY;
    IN_READY = ~RST & (~s1_valid_q | s2_load);
    accept   = IN_VALID & IN_READY;
  end

  // Address counter: a same-cycle load takes effect for the accepted request.
  always_comb begin
    load_addr  = ADDR_VAL & 32'hFFFF_FFFC;
    entry_addr = ADDR_LOAD ? load_addr : addr_q;
    addr_d     = addr_q;
    if (accept) begin
      addr_d = entry_addr + 32'd4;
    end else if (ADDR_LOAD) begin
      addr_d = load_addr;
    end
  end

  // Stage 1 next state: capture on accept, otherwise hold until stage 2 takes it.
  always_comb begin
    s1_valid_d = accept | (s1_valid_q & ~s2_load);
    s1_d       = s1_q;
    if (accept) begin
      s1_d.fmt    = in_fmt;
      s1_d.opcode = IN_OPCODE;
      s1_d.rd     = IN_RD;
      s1_d.rs1    = IN_RS1;
      s1_d.rs2    = IN_RS2;
      s1_d.funct3 = IN_FUNCT3;
      s1_d.funct7 = IN_FUNCT7;
      s1_d.imm    = IN_IMM;
      s1_d.addr   = entry_addr;
      s1_d.err    = ~in_legal;
    end
  end

  // Stage 1 and address counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      addr_q     <= RESET_ADDR;
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else begin
      addr_q     <= addr_d;
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
    end
  end

  // Scatter fields and immediate into RV32I positions for the latched format.
  always_comb begin
    packed_ins = '0;
    case (s1_q.fmt)
      FMT_I: packed_ins = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      FMT_S: packed_ins = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                           s1_q.imm[4:0], s1_q.opcode};
      FMT_B: packed_ins = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                           s1_q.imm[4:1], s1_q.imm[11], s1_q.opcode};
      FMT_U: packed_ins = {s1_q.imm[31:12], s1_q.rd, s1_q.opcode};
      FMT_J: packed_ins = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11], s1_q.imm[19:12],
                           s1_q.rd, s1_q.opcode};
      default: packed_ins = {s1_q.funct7, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd,
                             s1_q.opcode};
    endcase
    if (s1_q.err) begin
      packed_ins = NOP_WORD;
    end
  end

  // Output stage next state: reload from stage 1 when allowed, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_ins_d   = out_ins_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_ins_d  = packed_ins;
        out_addr_d = s1_q.addr;
        out_err_d  = s1_q.err;
      end
    end
  end

  // Saturating count of rejected requests, counted at accept.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && !in_legal && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Output stage and error counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid_q <= 1'b0;
      out_ins_q   <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_ins_q   <= out_ins_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign OUT_INS   = out_ins_q;
  assign OUT_ADDR  = out_addr_q;
  assign OUT_ERR   = out_err_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_ins_encoder.sv
// tb_ins_encoder: randomized and directed checks of ins_encoder against a
// scoreboard whose expectations come from signed immediate ranges, an
// immediate-extender decode of the produced word, and a byte-address model.
module tb_ins_encoder;

  localparam logic [31:0] RST_ADDR = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [2:0]  T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5;

  logic        CLK;
  logic        RST;
  logic        IN_VALID, IN_READY;
  logic [2:0]  IN_TYPE;
  logic [6:0]  IN_OPCODE, IN_FUNCT7;
  logic [4:0]  IN_RD, IN_RS1, IN_RS2;
  logic [2:0]  IN_FUNCT3;
  logic [31:0] IN_IMM;
  logic        ADDR_LOAD;
  logic [31:0] ADDR_VAL;
  logic        OUT_VALID, OUT_READY, OUT_ERR;
  logic [31:0] OUT_INS, OUT_ADDR;
  logic [7:0]  ERR_CNT;

  ins_encoder #(
    .RESET_ADDR(RST_ADDR),
    .NOP_WORD  (NOP),
    .ERR_CNT_W (8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_TYPE(IN_TYPE),
    .IN_OPCODE(IN_OPCODE), .IN_RD(IN_RD), .IN_RS1(IN_RS1), .IN_RS2(IN_RS2),
    .IN_FUNCT3(IN_FUNCT3), .IN_FUNCT7(IN_FUNCT7), .IN_IMM(IN_IMM),
    .ADDR_LOAD(ADDR_LOAD), .ADDR_VAL(ADDR_VAL),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_INS(OUT_INS),
    .OUT_ADDR(OUT_ADDR), .OUT_ERR(OUT_ERR), .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] addr;
    logic        err;
    logic        has_word;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_addr = RST_ADDR;
  int unsigned m_errs = 0;
  logic        last_acc = 1'b0;
  logic        has_word_r = 1'b0;
  logic [31:0] word_r = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_ins, prev_addr;
  logic        prev_err;

  logic [2:0]  bnd_t [8] = '{T_I, T_I, T_I, T_I, T_J, T_J, T_B, T_S};
  logic [31:0] bnd_i [8] = '{32'h0000_07FF, 32'h0000_0800, 32'hFFFF_F800, 32'hFFFF_F7FF,
                             32'h000F_FFFE, 32'h0010_0000, 32'h0000_0FFE, 32'hFFFF_F7FF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] norm(input logic [2:0] t);
    if (t >= T_I && t <= T_J) return t;
    return T_R;
  endfunction

  // Representable iff the value fits the format's signed range (and alignment).
  function automatic bit legal(input logic [2:0] t, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (t)
      T_I, T_S: return (s >= -2048) && (s <= 2047);
      T_B:      return (s >= -4096) && (s <= 4095) && ((s % 2) == 0);
      T_J:      return (s >= -1048576) && (s <= 1048575) && ((s % 2) == 0);
      T_U:      return (imm % 32'd4096) == 0;
      default:  return 1'b1;
    endcase
  endfunction

  // Decode-stage immediate extender, used to invert the encoded word.
  function automatic logic [31:0] imm_of(input logic [2:0] t, input logic [31:0] w);
    case (t)
      T_I:     return {{20{w[31]}}, w[31:20]};
      T_S:     return {{20{w[31]}}, w[31:25], w[11:7]};
      T_B:     return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      T_U:     return {w[31:12], 12'h000};
      T_J:     return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Bits of the word that hold register/opcode/funct fields for a format.
  function automatic logic [31:0] field_mask(input logic [2:0] t);
    case (t)
      T_I:      return {12'h000, 20'hF_FFFF};
      T_S, T_B: return {7'h00, 5'h1F, 5'h1F, 3'h7, 5'h00, 7'h7F};
      T_U, T_J: return {20'h0_0000, 5'h1F, 7'h7F};
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] fields_of(input exp_t e);
    return {e.f7, e.rs2, e.rs1, e.f3, e.rd, e.op} & field_mask(e.fmt);
  endfunction

  function automatic logic [31:0] rand_imm(input logic [2:0] t);
    logic [31:0] r;
    r = $urandom;
    case (t)
      T_I, T_S: return {{20{r[11]}}, r[11:0]};
      T_B:      return {{19{r[12]}}, r[12:1], 1'b0};
      T_J:      return {{11{r[20]}}, r[20:1], 1'b0};
      T_U:      return {r[31:12], 12'h000};
      default:  return r;
    endcase
  endfunction

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic cycle();
    exp_t e;
    logic acc;
    #1;
    if (RST) begin
      check("rdy_in_rst", 32'(IN_READY), 32'd0);
      sb.delete();
      m_addr    = RST_ADDR;
      m_errs    = 0;
      prev_hold = 1'b0;
      last_acc  = 1'b0;
    end else begin
      check("err_cnt", 32'(ERR_CNT), m_errs);
      if (prev_hold) begin
        check("hold_valid", 32'(OUT_VALID), 32'd1);
        check("hold_ins", OUT_INS, prev_ins);
        check("hold_addr", OUT_ADDR, prev_addr);
        check("hold_err", 32'(OUT_ERR), 32'(prev_err));
      end
      if (OUT_VALID && OUT_READY) begin
        if (sb.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_addr", OUT_ADDR, e.addr);
          check("out_err", 32'(OUT_ERR), 32'(e.err));
          if (e.err) begin
            check("nop_word", OUT_INS, NOP);
          end else begin
            check("fields", OUT_INS & field_mask(e.fmt), fields_of(e));
            if (e.fmt != T_R) check("imm_roundtrip", imm_of(e.fmt, OUT_INS), e.imm);
          end
          if (e.has_word) check("word", OUT_INS, e.word);
        end
      end
      acc = IN_VALID && IN_READY;
      last_acc = acc;
      if (acc) begin
        e.fmt = norm(IN_TYPE); e.op = IN_OPCODE; e.rd = IN_RD; e.rs1 = IN_RS1;
        e.rs2 = IN_RS2; e.f3 = IN_FUNCT3; e.f7 = IN_FUNCT7; e.imm = IN_IMM;
        e.addr = ADDR_LOAD ? (ADDR_VAL & ~32'd3) : m_addr;
        m_addr = e.addr + 32'd4;
        e.err = !legal(e.fmt, IN_IMM);
        if (e.err && m_errs < 255) m_errs++;
        e.has_word = has_word_r; e.word = word_r;
        sb.push_back(e);
      end else if (ADDR_LOAD) begin
        m_addr = ADDR_VAL & ~32'd3;
      end
      check("in_flight_le2", 32'(sb.size() > 2), 32'd0);
      prev_hold = OUT_VALID && !OUT_READY;
      prev_ins  = OUT_INS;
      prev_addr = OUT_ADDR;
      prev_err  = OUT_ERR;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic set_req(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic hw, input logic [31:0] w);
    IN_TYPE = t; IN_OPCODE = op; IN_RD = rd; IN_RS1 = rs1; IN_RS2 = rs2;
    IN_FUNCT3 = f3; IN_FUNCT7 = f7; IN_IMM = imm; IN_VALID = 1'b1;
    has_word_r = hw; word_r = w;
  endtask

  task automatic wait_acc();
    last_acc = 1'b0;
    for (int i = 0; i < 20 && !last_acc; i++) cycle();
    if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
    IN_VALID = 1'b0;
    has_word_r = 1'b0;
  endtask

  task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic hw, input logic [31:0] w);
    set_req(t, op, rd, rs1, rs2, f3, f7, imm, hw, w);
    wait_acc();
  endtask

  task automatic drain();
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
    check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset(input int unsigned n);
    RST = 1'b1; IN_VALID = 1'b0; ADDR_LOAD = 1'b0;
    for (int unsigned i = 0; i < n; i++) cycle();
    RST = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; IN_TYPE = '0; IN_OPCODE = '0; IN_RD = '0; IN_RS1 = '0;
    IN_RS2 = '0; IN_FUNCT3 = '0; IN_FUNCT7 = '0; IN_IMM = '0; ADDR_LOAD = 1'b0;
    ADDR_VAL = '0; OUT_READY = 1'b1;
    @(negedge CLK);
    do_reset(2);
    #1;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out_ins", OUT_INS, 32'd0);
    check("rst_out_addr", OUT_ADDR, 32'd0);
    check("rst_out_err", 32'(OUT_ERR), 32'd0);
    check("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    check("rst_in_ready", 32'(IN_READY), 32'd1);

    // I-type and latency: valid appears two clocks after the accept cycle.
    set_req(T_I, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0093);
    cycle();
    check("acc_I", 32'(last_acc), 32'd1);
    IN_VALID = 1'b0; has_word_r = 1'b0;
    #1 check("lat_1", 32'(OUT_VALID), 32'd0);
    cycle();
    #1 check("lat_2", 32'(OUT_VALID), 32'd1);
    cycle();

    // B-type legal then misaligned; U-type legal then low bits set; R via code 7.
    send(T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
    send(T_B, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0000_0003, 1'b1, NOP);
    drain();
    check("err_cnt_B", 32'(ERR_CNT), 32'd1);
    send(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    send(T_U, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 1'b1, NOP);
    send(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd7, 7'h20, 32'hDEAD_BEEF, 1'b1, 32'h4052_71B3);
    drain();
    check("err_cnt_U", 32'(ERR_CNT), 32'd2);

    // Range boundaries.
    for (int i = 0; i < 8; i++)
      send(bnd_t[i], 7'h6F, 5'd7, 5'd8, 5'd9, 3'd2, 7'd0, bnd_i[i], 1'b0, 32'd0);
    drain();

    // Backpressure: two entries fill the pipe, the third waits.
    do_reset(1);
    OUT_READY = 1'b0;
    set_req(T_I, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd1, 1'b1, 32'h0011_8113);
    cycle();
    set_req(T_I, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd2, 1'b1, 32'h0021_8113);
    cycle();
    set_req(T_I, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd3, 1'b1, 32'h0031_8113);
    #1 check("bp_in_ready_low", 32'(IN_READY), 32'd0);
    cycle();
    check("bp_third_held", 32'(last_acc), 32'd0);
    cycle();
    OUT_READY = 1'b1;
    wait_acc();
    drain();

    // Reset with both stages occupied, one of them in error.
    OUT_READY = 1'b0;
    send(T_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 32'd0);
    send(T_I, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b0, 32'd0);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    #1;
    check("rst_mid_valid", 32'(OUT_VALID), 32'd0);
    check("rst_mid_err_cnt", 32'(ERR_CNT), 32'd0);
    OUT_READY = 1'b1;
    send(T_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_1000, 1'b1, 32'h0000_10B7);
    cycle();
    #1 check("rst_next_addr", OUT_ADDR, RST_ADDR);
    drain();

    // Address load coincident with accept, then wrap at the top of memory.
    set_req(T_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, 32'd0);
    ADDR_LOAD = 1'b1; ADDR_VAL = 32'h0000_0103;
    wait_acc();
    ADDR_LOAD = 1'b0;
    send(T_I, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4, 1'b0, 32'd0);
    #1 check("ld_addr", OUT_ADDR, 32'h0000_0100);
    cycle();
    #1 check("ld_next_addr", OUT_ADDR, 32'h0000_0104);
    drain();
    ADDR_LOAD = 1'b1; ADDR_VAL = 32'hFFFF_FFFE;
    cycle();
    ADDR_LOAD = 1'b0;
    send(T_I, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0);
    send(T_I, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 1'b0, 32'd0);
    #1 check("wrap_top", OUT_ADDR, 32'hFFFF_FFFC);
    cycle();
    #1 check("wrap_zero", OUT_ADDR, 32'h0000_0000);
    drain();

    // Random traffic with random backpressure and occasional address loads.
    do_reset(1);
    for (int i = 0; i < 500; i++) begin
      IN_TYPE   = 3'($urandom_range(0, 7));
      IN_OPCODE = 7'($urandom); IN_RD = 5'($urandom); IN_RS1 = 5'($urandom);
      IN_RS2    = 5'($urandom); IN_FUNCT3 = 3'($urandom); IN_FUNCT7 = 7'($urandom);
      IN_IMM    = ($urandom_range(0, 3) != 0) ? rand_imm(norm(IN_TYPE)) : $urandom;
      IN_VALID  = ($urandom_range(0, 9) < 7);
      OUT_READY = ($urandom_range(0, 9) < 7);
      ADDR_LOAD = ($urandom_range(0, 31) == 0);
      ADDR_VAL  = $urandom;
      has_word_r = 1'b0;
      cycle();
    end
    ADDR_LOAD = 1'b0;
    drain();

    // Error counter saturation.
    set_req(T_U, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 1'b0, 32'd0);
    for (int i = 0; i < 270; i++) cycle();
    IN_VALID = 1'b0;
    drain();
    check("err_cnt_sat", 32'(ERR_CNT), 32'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
